// File: rtl/rate_counter_pkg.sv
// Shared speed encodings and period/width helpers for the rate-divided counter.
package rate_counter_pkg;

  typedef enum logic [1:0] {
    SPEED_FULL    = 2'b00,
    SPEED_1HZ     = 2'b01,
    SPEED_HALF    = 2'b10,
    SPEED_QUARTER = 2'b11
  } speed_e;

  // Wide enough to hold the slowest period minus one.
  function automatic int unsigned divider_width(input int unsigned freq);
    return 32'($clog2(4 * freq)) + 32'd1;
  endfunction

  // Divider period in ClockIn cycles; callers cast down to their divider width.
  function automatic logic [31:0] period(input logic [1:0] speed, input int unsigned freq);
    logic [31:0] p;
    p = 32'd1;
    case (speed)
      SPEED_FULL:    p = 32'd1;
      SPEED_1HZ:     p = 32'(freq);
      SPEED_HALF:    p = 32'(2 * freq);
      SPEED_QUARTER: p = 32'(4 * freq);
      default:       p = 32'd1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rate_counter_gen_divider.sv
// Programmable clock-enable divider: down-counter, registered speed copy and tick decode.
module rate_divider_gen
  import rate_counter_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic [1:0] Speed,
  input  logic       Enable,
  input  logic       Restart,
  output logic       Tick
);

  localparam int unsigned DW = divider_width(CLOCK_FREQUENCY);

  logic [DW-1:0] div_q, div_d, reload_c;
  logic [1:0]    speed_q, speed_d;
  logic          speed_changed_c;

  assign reload_c        = DW'(period(Speed, CLOCK_FREQUENCY) - 32'd1);
  assign speed_changed_c = (Speed != speed_q);
  assign Tick            = (div_q == '0) && Enable && !speed_changed_c && !Restart;

  // A restart or speed change always reloads, even while paused.
  always_comb begin
    div_d   = div_q;
    speed_d = speed_q;
    if (Restart || speed_changed_c) begin
      div_d   = reload_c;
      speed_d = Speed;
    end else if (Enable) begin
      div_d = (div_q == '0) ? reload_c : div_q - DW'(1);
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      div_q   <= reload_c;
      speed_q <= Speed;
    end else begin
      div_q   <= div_d;
      speed_q <= speed_d;
    end
  end

endmodule

// File: rtl/rate_counter_gen.sv
// Rate-divided up/down counter with load, pause, wrap/saturate and terminal pulse.
module rate_counter_gen
  import rate_counter_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned WIDTH           = 4
) (
  input  logic             ClockIn,
  input  logic             Reset,
  input  logic [1:0]       Speed,
  input  logic             Enable,
  input  logic             Dir,
  input  logic             Saturate,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] CounterValue,
  output logic             Tick,
  output logic             Terminal
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             terminal_q, terminal_d;
  logic             tick_c;

  rate_divider_gen #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
  ) u_divider (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .Speed   (Speed),
    .Enable  (Enable),
    .Restart (Load),
    .Tick    (tick_c)
  );

  // Load beats a step; a step at either limit wraps or clamps and flags Terminal.
  always_comb begin
    count_d    = count_q;
    terminal_d = 1'b0;
    if (Load) begin
      count_d = LoadValue;
    end else if (tick_c) begin
      if (Dir) begin
        if (count_q == COUNT_MAX) begin
          count_d    = Saturate ? COUNT_MAX : '0;
          terminal_d = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d    = Saturate ? '0 : COUNT_MAX;
          terminal_d = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      count_q    <= '0;
      terminal_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      terminal_q <= terminal_d;
    end
  end

  assign CounterValue = count_q;
  assign Terminal     = terminal_q;
  assign Tick         = tick_c;

endmodule

// File: tb/tb_rate_counter_gen.sv
// Directed bench for rate_counter_gen with CLOCK_FREQUENCY=4 (periods 1/4/8/16), WIDTH=4.
module tb_rate_counter_gen;

  typedef struct packed {
    logic [3:0] cnt;
    logic       tick;
    logic       term;
  } exp_t;

  logic       ClockIn = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] Speed = 2'b00;
  logic       Enable = 1'b1;
  logic       Dir = 1'b1;
  logic       Saturate = 1'b0;
  logic       Load = 1'b0;
  logic [3:0] LoadValue = 4'd0;
  logic [3:0] CounterValue;
  logic       Tick;
  logic       Terminal;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fails = 0;

  rate_counter_gen #(
    .CLOCK_FREQUENCY(4),
    .WIDTH(4)
  ) dut (
    .ClockIn      (ClockIn),
    .Reset        (Reset),
    .Speed        (Speed),
    .Enable       (Enable),
    .Dir          (Dir),
    .Saturate     (Saturate),
    .Load         (Load),
    .LoadValue    (LoadValue),
    .CounterValue (CounterValue),
    .Tick         (Tick),
    .Terminal     (Terminal)
  );

  always #5 ClockIn = ~ClockIn;

  task automatic adv();
    @(negedge ClockIn);
  endtask

  // Expected outputs are queued with the stimulus, then popped and compared 1 ns later.
  task automatic chk(input string tag, input logic [3:0] c, input logic tk, input logic tm);
    exp_t e;
    e.cnt = c;
    e.tick = tk;
    e.term = tm;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_asserts++;
    assert (CounterValue === e.cnt) else begin
      n_fails++;
      $error("FAIL %s count: observed %0d expected %0d", tag, CounterValue, e.cnt);
    end
    n_asserts++;
    assert (Tick === e.tick) else begin
      n_fails++;
      $error("FAIL %s tick: observed %b expected %b", tag, Tick, e.tick);
    end
    n_asserts++;
    assert (Terminal === e.term) else begin
      n_fails++;
      $error("FAIL %s terminal: observed %b expected %b", tag, Terminal, e.term);
    end
  endtask

  // Leaves the bench at a falling edge with Reset just released.
  task automatic do_reset(input logic [1:0] spd);
    adv();
    Reset = 1'b1;
    Speed = spd;
    Load  = 1'b0;
    adv();
    adv();
    Reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Full speed up-count with wrap
    Dir = 1'b1; Enable = 1'b1; Saturate = 1'b0;
    do_reset(2'b00);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) adv();
      chk("full_up", 4'(i % 16), 1'b1, i == 16);
    end

    // 1 Hz: one step every 4 edges
    do_reset(2'b01);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) adv();
      chk("speed_1hz", 4'(i / 4), (i % 4) == 3, 1'b0);
    end

    // Quarter speed, switch to 1 Hz at divider=9, then to half exactly at divider==0
    do_reset(2'b11);
    for (int i = 0; i < 24; i++) begin
      if (i > 0) adv();
      Speed = (i < 6) ? 2'b11 : ((i < 14) ? 2'b01 : 2'b10);
      chk("speed_change", (i >= 23) ? 4'd2 : ((i >= 11) ? 4'd1 : 4'd0),
          (i == 10) || (i == 22), 1'b0);
    end

    // Saturating down-count from a load
    do_reset(2'b00);
    Dir = 1'b0; Saturate = 1'b1; Load = 1'b1; LoadValue = 4'd2;
    chk("sat_down_load", 4'd0, 1'b0, 1'b0);
    adv(); Load = 1'b0;
    chk("sat_down_2", 4'd2, 1'b1, 1'b0);
    adv(); chk("sat_down_1", 4'd1, 1'b1, 1'b0);
    adv(); chk("sat_down_0", 4'd0, 1'b1, 1'b0);
    adv(); Enable = 1'b0;
    chk("sat_down_clamp", 4'd0, 1'b0, 1'b1);
    adv(); chk("sat_down_after", 4'd0, 1'b0, 1'b0);
    Enable = 1'b1;

    // Load coinciding with a tick
    Dir = 1'b1; Saturate = 1'b0;
    do_reset(2'b01);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) adv();
      chk("load_tick_pre", 4'd0, 1'b0, 1'b0);
    end
    adv(); Load = 1'b1; LoadValue = 4'd7;
    chk("load_tick_same", 4'd0, 1'b0, 1'b0);
    adv(); Load = 1'b0;
    chk("load_tick_val", 4'd7, 1'b0, 1'b0);
    adv(); chk("load_tick_d2", 4'd7, 1'b0, 1'b0);
    adv(); chk("load_tick_d1", 4'd7, 1'b0, 1'b0);
    adv(); chk("load_tick_d0", 4'd7, 1'b1, 1'b0);
    adv(); chk("load_tick_step", 4'd8, 1'b0, 1'b0);

    // Saturate at max going up, then wrap going down
    do_reset(2'b00);
    Dir = 1'b1; Saturate = 1'b1; Load = 1'b1; LoadValue = 4'd15;
    chk("limits_load", 4'd0, 1'b0, 1'b0);
    adv(); Load = 1'b0;
    chk("limits_max", 4'd15, 1'b1, 1'b0);
    adv(); Dir = 1'b0; Saturate = 1'b0;
    chk("limits_clamp_up", 4'd15, 1'b1, 1'b1);
    adv(); Load = 1'b1; LoadValue = 4'd0;
    chk("limits_dec", 4'd14, 1'b0, 1'b0);
    adv(); Load = 1'b0;
    chk("limits_zero", 4'd0, 1'b1, 1'b0);
    adv(); Enable = 1'b0;
    chk("limits_wrap_down", 4'd15, 1'b0, 1'b1);
    adv(); chk("limits_paused", 4'd15, 1'b0, 1'b0);
    Enable = 1'b1;

    // Pause for 10 cycles mid-period, then finish the remaining count
    Dir = 1'b1; Saturate = 1'b0;
    do_reset(2'b01);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) adv();
      Enable = (i >= 1 && i <= 10) ? 1'b0 : 1'b1;
      chk("pause", (i >= 14) ? 4'd1 : 4'd0, i == 13, 1'b0);
    end

    // Reset mid-period at value 9
    do_reset(2'b01);
    Load = 1'b1; LoadValue = 4'd9;
    chk("midreset_load", 4'd0, 1'b0, 1'b0);
    adv(); Load = 1'b0;
    chk("midreset_9a", 4'd9, 1'b0, 1'b0);
    adv(); chk("midreset_9b", 4'd9, 1'b0, 1'b0);
    adv(); Reset = 1'b1;
    chk("midreset_assert", 4'd9, 1'b0, 1'b0);
    adv(); Reset = 1'b0;
    chk("midreset_zero", 4'd0, 1'b0, 1'b0);
    adv(); chk("midreset_d2", 4'd0, 1'b0, 1'b0);
    adv(); chk("midreset_d1", 4'd0, 1'b0, 1'b0);
    adv(); chk("midreset_d0", 4'd0, 1'b1, 1'b0);
    adv(); chk("midreset_step", 4'd1, 1'b0, 1'b0);

    // Reset on a wrapping edge suppresses Terminal
    do_reset(2'b00);
    Load = 1'b1; LoadValue = 4'd15;
    chk("reset_term_load", 4'd0, 1'b0, 1'b0);
    adv(); Load = 1'b0; Reset = 1'b1;
    chk("reset_term_max", 4'd15, 1'b1, 1'b0);
    adv(); Reset = 1'b0;
    chk("reset_term_clear", 4'd0, 1'b1, 1'b0);
    adv(); chk("reset_term_run", 4'd1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
